// File: rtl/zombie_motion.sv
// Zombie lanes: one FSM slot per lane (spawn, walk, hits, dying) and a
// registered pixel hit test that yields the sprite ROM address.

module zombie_lane #(
    parameter int SPAWN_X      = 600,
    parameter int GOAL_X       = 40,
    parameter int HP_INIT      = 10,
    parameter int SPEED_DIV    = 4,
    parameter int DEATH_FRAMES = 30
) (
    input  logic       CLK,
    input  logic       Reset_n,
    input  logic       i_frame,
    input  logic       i_spawn,
    input  logic       i_hit,
    input  logic       i_frozen,
    output logic       o_walk,
    output logic       o_dying,
    output logic [9:0] o_x,
    output logic       o_goal
);
    localparam int SW = (SPEED_DIV > 1) ? $clog2(SPEED_DIV) : 1;
    localparam int DW = (DEATH_FRAMES > 1) ? $clog2(DEATH_FRAMES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WALK, S_DYING} lane_st_t;

    lane_st_t        r_st;
    logic [9:0]      r_x;
    logic [3:0]      r_hp;
    logic [SW-1:0]   r_spd;
    logic [DW-1:0]   r_die;

    logic            w_kill;
    logic            w_step;
    logic [9:0]      w_x_next;

    assign w_kill   = i_hit && (r_hp == 4'd1);
    assign w_step   = i_frame && (r_spd == SW'(SPEED_DIV - 1));
    assign w_x_next = w_step ? (r_x - 10'd1) : r_x;
    // A killing hit suppresses the move, so it also suppresses the goal check.
    assign o_goal   = !i_frozen && (r_st == S_WALK) && i_frame && !w_kill &&
                      (w_x_next <= 10'(GOAL_X));

    // Per-lane state machine; everything freezes once the game is over.
    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            r_st  <= S_IDLE;
            r_x   <= 10'(SPAWN_X);
            r_hp  <= 4'd0;
            r_spd <= '0;
            r_die <= '0;
        end else if (!i_frozen) begin
            case (r_st)
                S_IDLE: if (i_spawn) begin
                    r_st  <= S_WALK;
                    r_x   <= 10'(SPAWN_X);
                    r_hp  <= 4'(HP_INIT);
                    r_spd <= '0;
                end
                S_WALK: begin
                    if (w_kill) begin
                        r_st  <= S_DYING;
                        r_hp  <= 4'd0;
                        r_die <= '0;
                    end else begin
                        if (i_hit)
                            r_hp <= r_hp - 4'd1;
                        if (i_frame) begin
                            r_x   <= w_x_next;
                            r_spd <= w_step ? '0 : r_spd + SW'(1);
                        end
                    end
                end
                S_DYING: if (i_frame) begin
                    if (r_die == DW'(DEATH_FRAMES - 1)) begin
                        r_st  <= S_IDLE;
                        r_die <= '0;
                    end else begin
                        r_die <= r_die + DW'(1);
                    end
                end
                default: r_st <= S_IDLE;
            endcase
        end
    end

    assign o_walk  = (r_st == S_WALK);
    assign o_dying = (r_st == S_DYING);
    assign o_x     = r_x;
endmodule

module zombie_motion #(
    parameter int LANES        = 5,
    parameter int LANE_Y0      = 90,
    parameter int LANE_H       = 80,
    parameter int ZW           = 40,
    parameter int ZH           = 60,
    parameter int SPAWN_X      = 600,
    parameter int GOAL_X       = 40,
    parameter int HP_INIT      = 10,
    parameter int SPEED_DIV    = 4,
    parameter int ANIM_DIV     = 8,
    parameter int DEATH_FRAMES = 30
) (
    input  logic             CLK,
    input  logic             Reset_n,
    input  logic             frame_start,
    input  logic             spawn,
    input  logic [2:0]       spawn_row,
    input  logic             hit,
    input  logic [2:0]       hit_row,
    input  logic [9:0]       DrawX,
    input  logic [9:0]       DrawY,
    output logic             zom_on,
    output logic [18:0]      read_address_zom,
    output logic             END_on,
    output logic [LANES-1:0] zom_alive
);
    localparam int AW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    logic                  r_end;
    logic [AW-1:0]         r_anim_cnt;
    logic                  r_anim_frame;
    logic                  r_zom_on;
    logic [18:0]           r_addr;

    logic [LANES-1:0]      w_walk, w_dying, w_goal, w_in;
    logic [LANES-1:0][9:0] w_x, w_dx, w_dy;
    logic [LANES-1:0][1:0] w_frm;
    logic                  w_pix;
    logic [18:0]           w_addr;

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            localparam logic [9:0] LY = 10'(LANE_Y0 + g * LANE_H);

            zombie_lane #(
                .SPAWN_X(SPAWN_X), .GOAL_X(GOAL_X), .HP_INIT(HP_INIT),
                .SPEED_DIV(SPEED_DIV), .DEATH_FRAMES(DEATH_FRAMES)
            ) u_lane (
                .CLK     (CLK),
                .Reset_n (Reset_n),
                .i_frame (frame_start),
                .i_spawn (spawn && (spawn_row == 3'(g))),
                .i_hit   (hit && (hit_row == 3'(g))),
                .i_frozen(r_end),
                .o_walk  (w_walk[g]),
                .o_dying (w_dying[g]),
                .o_x     (w_x[g]),
                .o_goal  (w_goal[g])
            );

            // 11-bit compares keep x+ZW from wrapping near the right edge.
            assign w_in[g] = (w_walk[g] || w_dying[g]) &&
                             (DrawX >= w_x[g]) &&
                             ({1'b0, DrawX} < ({1'b0, w_x[g]} + 11'(ZW))) &&
                             (DrawY >= LY) &&
                             ({1'b0, DrawY} < ({1'b0, LY} + 11'(ZH)));
            assign w_dx[g]  = DrawX - w_x[g];
            assign w_dy[g]  = DrawY - LY;
            assign w_frm[g] = w_dying[g] ? 2'd2 : {1'b0, r_anim_frame};
        end
    endgenerate

    // Lowest matching lane wins: scan downward so it is assigned last.
    always_comb begin
        w_pix  = 1'b0;
        w_addr = '0;
        for (int r = LANES - 1; r >= 0; r--) begin
            if (w_in[r]) begin
                w_pix  = 1'b1;
                w_addr = 19'(w_frm[r]) * 19'(ZW * ZH) +
                         19'(w_dy[r]) * 19'(ZW) + 19'(w_dx[r]);
            end
        end
    end

    // Game-over flag, walk animation and registered pixel outputs.
    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            r_end        <= 1'b0;
            r_anim_cnt   <= '0;
            r_anim_frame <= 1'b0;
            r_zom_on     <= 1'b0;
            r_addr       <= '0;
        end else begin
            r_end <= r_end | (|w_goal);
            if (frame_start) begin
                if (r_anim_cnt == AW'(ANIM_DIV - 1)) begin
                    r_anim_cnt   <= '0;
                    r_anim_frame <= ~r_anim_frame;
                end else begin
                    r_anim_cnt <= r_anim_cnt + AW'(1);
                end
            end
            r_zom_on <= w_pix;
            r_addr   <= w_addr;
        end
    end

    assign zom_on           = r_zom_on;
    assign read_address_zom = r_addr;
    assign END_on           = r_end;
    assign zom_alive        = w_walk;
endmodule
